// File: rtl/line_fill_mem_responder_if.sv
// rtl/line_fill_mem_responder_if.sv - line-fill read bus plus store load port.
// Optional mem_err signal exists only when MEM_RANGE_CHECK_EN is defined.
interface line_fill_mem_responder_if #(
  parameter int AW = 10
);
  logic [31:0]   mem_bus_address;
  logic          mem_read_start;
  logic [127:0]  mem_bus_data;
  logic          mem_read_rdy;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          busy;
`ifdef MEM_RANGE_CHECK_EN
  logic          mem_err;

  modport master (
    output mem_bus_address, mem_read_start, ld_we, ld_addr, ld_data,
    input  mem_bus_data, mem_read_rdy, busy, mem_err
  );
  modport slave (
    input  mem_bus_address, mem_read_start, ld_we, ld_addr, ld_data,
    output mem_bus_data, mem_read_rdy, busy, mem_err
  );
`else
  modport master (
    output mem_bus_address, mem_read_start, ld_we, ld_addr, ld_data,
    input  mem_bus_data, mem_read_rdy, busy
  );
  modport slave (
    input  mem_bus_address, mem_read_start, ld_we, ld_addr, ld_data,
    output mem_bus_data, mem_read_rdy, busy
  );
`endif
endinterface

// File: rtl/line_fill_mem_responder.sv
// rtl/line_fill_mem_responder.sv - memory-side responder returning 128-bit lines after a fixed latency.
// Optional MEM_RANGE_CHECK_EN flags requests with address bits above the store range.
module line_fill_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10,
  parameter int LATENCY     = 4
) (
  input logic clk,
  input logic reset_n,
  line_fill_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW-3:0] idx_q, idx_d;
  logic [127:0]  data_q, data_d;
  logic          rdy_q, rdy_d;
  logic          busy_q, busy_d;
  logic [127:0]  line_rd;
  logic [31:0]   store_q [DEPTH_WORDS];

  logic unused_addr_bits;
`ifdef MEM_RANGE_CHECK_EN
  logic oor_q, oor_d;
  logic err_q, err_d;
  assign unused_addr_bits = ^bus.mem_bus_address[3:0];
`else
  assign unused_addr_bits = ^{bus.mem_bus_address[31:AW+2], bus.mem_bus_address[3:0]};
`endif

  // Store is never reset; nonblocking write makes a same-edge line read see the old word.
  always_ff @(posedge clk) begin
    if (bus.ld_we) store_q[bus.ld_addr] <= bus.ld_data;
  end

  assign line_rd = {store_q[{idx_q, 2'd3}], store_q[{idx_q, 2'd2}],
                    store_q[{idx_q, 2'd1}], store_q[{idx_q, 2'd0}]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
    oor_d   = oor_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.mem_read_start) begin
          idx_d   = bus.mem_bus_address[AW+1:4];
          cnt_d   = 8'(LATENCY - 1);
`ifdef MEM_RANGE_CHECK_EN
          oor_d   = |bus.mem_bus_address[31:AW+2];
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!bus.mem_read_start) begin
          state_d = IDLE;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
`ifdef MEM_RANGE_CHECK_EN
          data_d = oor_q ? {4{32'hDEADBEEF}} : line_rd;
          err_d  = oor_q;
`else
          data_d = line_rd;
`endif
          rdy_d   = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!bus.mem_read_start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
`ifdef MEM_RANGE_CHECK_EN
      oor_q   <= oor_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.mem_bus_data = data_q;
  assign bus.mem_read_rdy = rdy_q;
  assign bus.busy         = busy_q;
`ifdef MEM_RANGE_CHECK_EN
  assign bus.mem_err      = err_q;
`endif

endmodule

// File: tb/tb_line_fill_mem_responder.sv
// tb/tb_line_fill_mem_responder.sv - scoreboard bench for line_fill_mem_responder.
// Honours MEM_RANGE_CHECK_EN the same way the design does.
module tb_line_fill_mem_responder;
  localparam int AW  = 10;
  localparam int LAT = 4;

  typedef struct {
    logic [127:0] data;
    logic         err;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t e_mon;
  logic [31:0] model [1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_fill_mem_responder_if #(.AW(AW)) bus ();

  line_fill_mem_responder #(.DEPTH_WORDS(1024), .AW(AW), .LATENCY(LAT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input int w);
    return {model[w+3], model[w+2], model[w+1], model[w]};
  endfunction

  // Monitor: every rdy pulse must match the oldest pending expectation.
  always @(posedge clk) begin
    #1;
    if (reset_n && bus.mem_read_rdy === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rdy: rdy=1 at cycle %0d, required 0", cyc);
      end else begin
        e_mon = sb.pop_front();
        chk("rdy_cycle", 128'(cyc), 128'(e_mon.cyc));
        chk("line_data", bus.mem_bus_data, e_mon.data);
`ifdef MEM_RANGE_CHECK_EN
        chk("mem_err", 128'(bus.mem_err), 128'(e_mon.err));
`endif
      end
    end
`ifdef MEM_RANGE_CHECK_EN
    else if (bus.mem_err !== 1'b0) begin
      n_chk++;
      n_fail++;
      $display("FAIL mem_err_idle: got %b at cycle %0d, required 0", bus.mem_err, cyc);
    end
`endif
  end

  task automatic load(input int a, input logic [31:0] d);
    bus.ld_we   = 1'b1;
    bus.ld_addr = a[AW-1:0];
    bus.ld_data = d;
    model[a]    = d;
    @(negedge clk);
  endtask

  // Called at a negedge; the following posedge samples the request.
  task automatic request(input logic [31:0] addr);
    exp_t e;
    int   w;
    w = int'(addr[AW+1:4]) * 4;
    bus.mem_bus_address = addr;
    bus.mem_read_start  = 1'b1;
    e.cyc  = cyc + 1 + LAT;
`ifdef MEM_RANGE_CHECK_EN
    e.err  = |addr[31:AW+2];
    e.data = e.err ? {4{32'hDEADBEEF}} : line_of(w);
`else
    e.err  = 1'b0;
    e.data = line_of(w);
`endif
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: %0d reads pending after %0d cycles, required 0", name, sb.size(), n);
      sb.delete();
    end
  endtask

  task automatic drop_start();
    bus.mem_read_start = 1'b0;
    @(negedge clk);
    chk("busy_after_drop", 128'(bus.busy), 128'(1'b0));
  endtask

  initial begin
    bus.mem_bus_address = '0;
    bus.mem_read_start  = 1'b0;
    bus.ld_we           = 1'b0;
    bus.ld_addr         = '0;
    bus.ld_data         = '0;
    repeat (3) @(negedge clk);
    chk("reset_rdy", 128'(bus.mem_read_rdy), 128'(1'b0));
    chk("reset_data", bus.mem_bus_data, 128'h0);
    chk("reset_busy", 128'(bus.busy), 128'(1'b0));
    reset_n = 1'b1;
    @(negedge clk);

    load(0, 32'h11111111); load(1, 32'h22222222);
    load(2, 32'h33333333); load(3, 32'h44444444);
    load(4, 32'h55555555); load(5, 32'h66666666);
    load(6, 32'h77777777); load(7, 32'h88888888);
    load(8, 32'hA0A0A0A0); load(9, 32'hA1A1A1A1);
    load(10, 32'hA2A2A2A2); load(11, 32'hA3A3A3A3);
    bus.ld_we = 1'b0;

    // Basic line, then start held past rdy: busy stays up, no second pulse.
    request(32'h0);
    wait_drain("t1");
    chk("t1_line_const", bus.mem_bus_data, 128'h44444444_33333333_22222222_11111111);
    repeat (3) begin
      @(negedge clk);
      chk("release_busy", 128'(bus.busy), 128'(1'b1));
    end
    drop_start();

    request(32'h1C);
    wait_drain("t2");
    chk("t2_line_const", bus.mem_bus_data, 128'h88888888_77777777_66666666_55555555);
    drop_start();

    // Abort after two BUSY cycles; data must stay at the last line.
    bus.mem_bus_address = 32'h20;
    bus.mem_read_start  = 1'b1;
    repeat (2) @(negedge clk);
    bus.mem_read_start = 1'b0;
    @(negedge clk);
    chk("abort_busy", 128'(bus.busy), 128'(1'b0));
    chk("abort_data_held", bus.mem_bus_data, 128'h88888888_77777777_66666666_55555555);

    // New request straight away; word 8 written on the very edge that reads it.
    request(32'h20);
    repeat (LAT) @(negedge clk);
    bus.ld_we   = 1'b1;
    bus.ld_addr = 10'd8;
    bus.ld_data = 32'hBBBBBBBB;
    @(negedge clk);
    bus.ld_we = 1'b0;
    model[8]  = 32'hBBBBBBBB;
    wait_drain("t4");
    drop_start();
    request(32'h20);
    wait_drain("t4_reread");
    drop_start();

    // Reset in the middle of BUSY.
    bus.mem_bus_address = 32'h0;
    bus.mem_read_start  = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_rdy", 128'(bus.mem_read_rdy), 128'(1'b0));
    chk("midreset_data", bus.mem_bus_data, 128'h0);
    chk("midreset_busy", 128'(bus.busy), 128'(1'b0));
    bus.mem_read_start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    request(32'h0);
    wait_drain("t5_reread");
    drop_start();

    // Upper address bits: error line with the check, alias of words 0..3 without.
    request(32'h8000_0000);
    wait_drain("t6");
    drop_start();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
